// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage constants, IF/ID record type and address helpers.
package if_fetch_stage_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic STALL_HOLD   = 1'b1;
  localparam logic STALL_RUN    = 1'b0;

  localparam logic [INST_BUS-1:0]      ZERO_WORD = 32'h0000_0000;
  localparam logic [INST_ADDR_BUS-1:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [INST_ADDR_BUS-1:0] pc;
    logic [INST_BUS-1:0]      inst;
    logic                     valid;
    logic                     misalign;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: 32'h0000_0000, inst: ZERO_WORD,
                                      valid: 1'b0, misalign: 1'b0};

  function automatic logic [INST_ADDR_BUS-1:0] word_align(input logic [INST_ADDR_BUS-1:0] addr);
    return {addr[INST_ADDR_BUS-1:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [INST_ADDR_BUS-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/if_fetch_stage_pc_reg.sv
// Program counter and ROM chip-enable; redirect priority flush > stall > branch > step.
module if_fetch_stage_pc_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_if_i,
  input  logic                     branch_flag_i,
  input  logic [INST_ADDR_BUS-1:0] branch_target_i,
  input  logic                     flush_i,
  input  logic [INST_ADDR_BUS-1:0] flush_pc_i,
  output logic [INST_ADDR_BUS-1:0] pc_o,
  output logic                     ce_o,
  output logic                     misalign_o
);

  logic [INST_ADDR_BUS-1:0] pc_r;
  logic                     ce_r;
  logic                     misalign_r;

  // PC, enable and misalign flag; pc is frozen at RESET_PC until ce has been enabled once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_r       <= CHIP_DISABLE;
      pc_r       <= RESET_PC;
      misalign_r <= 1'b0;
    end else begin
      ce_r <= CHIP_ENABLE;
      if (ce_r == CHIP_DISABLE) begin
        pc_r       <= RESET_PC;
        misalign_r <= 1'b0;
      end else if (flush_i) begin
        pc_r       <= word_align(flush_pc_i);
        misalign_r <= is_misaligned(flush_pc_i);
      end else if (stall_if_i == STALL_HOLD) begin
        pc_r       <= pc_r;
        misalign_r <= misalign_r;
      end else if (branch_flag_i) begin
        pc_r       <= word_align(branch_target_i);
        misalign_r <= is_misaligned(branch_target_i);
      end else begin
        pc_r       <= pc_r + PC_STEP;
        misalign_r <= 1'b0;
      end
    end
  end

  assign pc_o       = pc_r;
  assign ce_o       = ce_r;
  assign misalign_o = misalign_r;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: drives the instruction ROM and owns the IF/ID register.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] RESET_PC          = 32'h0000_0000,
  parameter bit                       BRANCH_DELAY_SLOT = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_if_i,
  input  logic                     stall_id_i,
  input  logic                     branch_flag_i,
  input  logic [INST_ADDR_BUS-1:0] branch_target_i,
  input  logic                     flush_i,
  input  logic [INST_ADDR_BUS-1:0] flush_pc_i,
  input  logic [INST_BUS-1:0]      rom_data_i,
  output logic [INST_ADDR_BUS-1:0] rom_addr_o,
  output logic                     rom_ce_o,
  output logic [INST_ADDR_BUS-1:0] id_pc_o,
  output logic [INST_BUS-1:0]      id_inst_o,
  output logic                     id_valid_o,
  output logic                     id_misalign_o
);

  logic [INST_ADDR_BUS-1:0] pc_s;
  logic                     ce_s;
  logic                     misalign_s;
  if_id_t                   if_id_r;
  logic                     squash_s;

  if_fetch_stage_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_if_i      (stall_if_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .flush_i         (flush_i),
    .flush_pc_i      (flush_pc_i),
    .pc_o            (pc_s),
    .ce_o            (ce_s),
    .misalign_o      (misalign_s)
  );

  // Without a delay slot the word fetched alongside a taken branch is on the wrong path.
  assign squash_s = branch_flag_i && (BRANCH_DELAY_SLOT == 1'b0);

  // IF/ID pipeline register; a disabled ROM yields a bubble rather than a valid zero word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_r <= IF_ID_BUBBLE;
    end else if (flush_i) begin
      if_id_r <= IF_ID_BUBBLE;
    end else if (stall_id_i == STALL_HOLD) begin
      if_id_r <= if_id_r;
    end else if (stall_if_i == STALL_HOLD) begin
      if_id_r <= IF_ID_BUBBLE;
    end else if (squash_s) begin
      if_id_r <= IF_ID_BUBBLE;
    end else if (ce_s == CHIP_DISABLE) begin
      if_id_r <= IF_ID_BUBBLE;
    end else begin
      if_id_r <= '{pc: pc_s, inst: rom_data_i, valid: 1'b1, misalign: misalign_s};
    end
  end

  assign rom_addr_o    = pc_s;
  assign rom_ce_o      = ce_s;
  assign id_pc_o       = if_id_r.pc;
  assign id_inst_o     = if_id_r.inst;
  assign id_valid_o    = if_id_r.valid;
  assign id_misalign_o = if_id_r.misalign;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: delay-slot DUT checked throughout, squash DUT on branch.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_if_i, stall_id_i, branch_flag_i, flush_i;
  logic [31:0] branch_target_i, flush_pc_i;
  logic [31:0] rom_data, rom_addr, id_pc, id_inst;
  logic        rom_ce, id_valid, id_mis;
  logic [31:0] rom_data0, rom_addr0, id_pc0, id_inst0;
  logic        rom_ce0, id_valid0, id_mis0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        mis;
  } exp_t;

  typedef struct packed {
    logic        si, sd, br, fl;
    logic [31:0] tgt, fpc, epc;
    logic        ev, em;
    logic [31:0] eaddr;
  } step_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h3401_8000;
    return {~a[15:0], a[15:0]};
  endfunction

  always_comb rom_data  = rom_ce  ? rom_word(rom_addr)  : 32'h0;
  always_comb rom_data0 = rom_ce0 ? rom_word(rom_addr0) : 32'h0;

  if_fetch_stage #(.RESET_PC(32'h0), .BRANCH_DELAY_SLOT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .stall_if_i(stall_if_i), .stall_id_i(stall_id_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i), .rom_data_i(rom_data),
    .rom_addr_o(rom_addr), .rom_ce_o(rom_ce), .id_pc_o(id_pc), .id_inst_o(id_inst),
    .id_valid_o(id_valid), .id_misalign_o(id_mis));

  if_fetch_stage #(.RESET_PC(32'h0), .BRANCH_DELAY_SLOT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .stall_if_i(stall_if_i), .stall_id_i(stall_id_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i), .rom_data_i(rom_data0),
    .rom_addr_o(rom_addr0), .rom_ce_o(rom_ce0), .id_pc_o(id_pc0), .id_inst_o(id_inst0),
    .id_valid_o(id_valid0), .id_misalign_o(id_mis0));

  // Decode must never stall while fetch runs on.
  always @(posedge clk) begin
    if (rst_n) assert (!(stall_id_i && !stall_if_i)) else $error("stall_id without stall_if");
  end

  function automatic step_t st(input logic si, sd, br, fl, input logic [31:0] tgt, fpc, epc,
                               input logic ev, em, input logic [31:0] eaddr);
    return '{si: si, sd: sd, br: br, fl: fl, tgt: tgt, fpc: fpc, epc: epc,
             ev: ev, em: em, eaddr: eaddr};
  endfunction

  function automatic step_t idle(input logic [31:0] epc, input logic em, input logic [31:0] eaddr);
    return st(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, epc, 1'b1, em, eaddr);
  endfunction

  // Drive one cycle of stimulus, queue what IF/ID must hold after the edge, then advance.
  task automatic apply(input step_t s);
    stall_if_i      = s.si;
    stall_id_i      = s.sd;
    branch_flag_i   = s.br;
    flush_i         = s.fl;
    branch_target_i = s.tgt;
    flush_pc_i      = s.fpc;
    sb.push_back('{pc: s.epc, inst: (s.ev ? rom_word(s.epc) : 32'h0), valid: s.ev, mis: s.em});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t s[4];
    exp_t  e;
    rst_n = 1'b0;
    apply(st(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
    void'(sb.pop_front());
    vectors++;
    if ({rom_ce, id_valid, id_mis, id_pc, id_inst, rom_addr} !== {1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_state: got ce=%b v=%b m=%b pc=%h inst=%h addr=%h, expected all zero",
               rom_ce, id_valid, id_mis, id_pc, id_inst, rom_addr);
    end
    rst_n = 1'b1;
    s[0] = st(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    s[1] = idle(32'h0, 1'b0, 32'h4);
    s[2] = idle(32'h4, 1'b0, 32'h8);
    s[3] = idle(32'h8, 1'b0, 32'hC);
    for (int i = 0; i < 4; i++) begin
      apply(s[i]);
      e = sb.pop_front();
      vectors++;
      if ({id_pc, id_inst, id_valid, id_mis} !== e) begin
        miscompares++;
        $display("FAIL reset_ifid[%0d]: got %h/%h/%b/%b expected %h/%h/%b/%b", i,
                 id_pc, id_inst, id_valid, id_mis, e.pc, e.inst, e.valid, e.mis);
      end
      vectors++;
      if ({rom_ce, rom_addr} !== {1'b1, s[i].eaddr}) begin
        miscompares++;
        $display("FAIL reset_fetch[%0d]: got ce=%b addr=%h expected ce=1 addr=%h", i, rom_ce, rom_addr, s[i].eaddr);
      end
    end
  endtask

  task automatic test_stall();
    step_t s[7];
    exp_t  e;
    s[0] = idle(32'hC, 1'b0, 32'h10);
    for (int i = 1; i < 4; i++)
      s[i] = st(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'hC, 1'b1, 1'b0, 32'h10);
    s[4] = idle(32'h10, 1'b0, 32'h14);
    s[5] = idle(32'h14, 1'b0, 32'h18);
    s[6] = idle(32'h18, 1'b0, 32'h1C);
    for (int i = 0; i < 7; i++) begin
      apply(s[i]);
      e = sb.pop_front();
      vectors++;
      if ({id_pc, id_inst, id_valid, id_mis} !== e) begin
        miscompares++;
        $display("FAIL stall_ifid[%0d]: got %h/%h/%b/%b expected %h/%h/%b/%b", i,
                 id_pc, id_inst, id_valid, id_mis, e.pc, e.inst, e.valid, e.mis);
      end
      vectors++;
      if (rom_addr !== s[i].eaddr) begin
        miscompares++;
        $display("FAIL stall_addr[%0d]: got %h expected %h", i, rom_addr, s[i].eaddr);
      end
    end
  endtask

  task automatic test_branch();
    step_t s[2];
    exp_t  e;
    s[0] = st(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h1C, 1'b1, 1'b0, 32'h40);
    s[1] = idle(32'h40, 1'b0, 32'h44);
    for (int i = 0; i < 2; i++) begin
      apply(s[i]);
      e = sb.pop_front();
      vectors++;
      if ({id_pc, id_inst, id_valid, id_mis} !== e) begin
        miscompares++;
        $display("FAIL branch_ifid[%0d]: got %h/%h/%b/%b expected %h/%h/%b/%b", i,
                 id_pc, id_inst, id_valid, id_mis, e.pc, e.inst, e.valid, e.mis);
      end
      vectors++;
      if ({rom_addr, rom_addr0} !== {s[i].eaddr, s[i].eaddr}) begin
        miscompares++;
        $display("FAIL branch_addr[%0d]: got %h/%h expected %h", i, rom_addr, rom_addr0, s[i].eaddr);
      end
      // The squashing variant must turn the delay-slot word into a bubble.
      vectors++;
      if ({id_pc0, id_inst0, id_valid0} !== ((i == 0) ? {32'h0, 32'h0, 1'b0} : {32'h40, rom_word(32'h40), 1'b1})) begin
        miscompares++;
        $display("FAIL branch_squash[%0d]: got pc=%h inst=%h v=%b", i, id_pc0, id_inst0, id_valid0);
      end
    end
  endtask

  task automatic test_flush();
    step_t s[2];
    exp_t  e;
    s[0] = st(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h180, 32'h0, 1'b0, 1'b0, 32'h180);
    s[1] = idle(32'h180, 1'b0, 32'h184);
    for (int i = 0; i < 2; i++) begin
      apply(s[i]);
      e = sb.pop_front();
      vectors++;
      if ({id_pc, id_inst, id_valid, id_mis} !== e) begin
        miscompares++;
        $display("FAIL flush_ifid[%0d]: got %h/%h/%b/%b expected %h/%h/%b/%b", i,
                 id_pc, id_inst, id_valid, id_mis, e.pc, e.inst, e.valid, e.mis);
      end
      vectors++;
      if (rom_addr !== s[i].eaddr) begin
        miscompares++;
        $display("FAIL flush_addr[%0d]: got %h expected %h", i, rom_addr, s[i].eaddr);
      end
    end
  endtask

  task automatic test_misalign();
    step_t s[3];
    exp_t  e;
    s[0] = st(1'b0, 1'b0, 1'b1, 1'b0, 32'h4A, 32'h0, 32'h184, 1'b1, 1'b0, 32'h48);
    s[1] = idle(32'h48, 1'b1, 32'h4C);
    s[2] = idle(32'h4C, 1'b0, 32'h50);
    for (int i = 0; i < 3; i++) begin
      apply(s[i]);
      e = sb.pop_front();
      vectors++;
      if ({id_pc, id_inst, id_valid, id_mis} !== e) begin
        miscompares++;
        $display("FAIL misalign_ifid[%0d]: got %h/%h/%b/%b expected %h/%h/%b/%b", i,
                 id_pc, id_inst, id_valid, id_mis, e.pc, e.inst, e.valid, e.mis);
      end
      vectors++;
      if (rom_addr !== s[i].eaddr) begin
        miscompares++;
        $display("FAIL misalign_addr[%0d]: got %h expected %h", i, rom_addr, s[i].eaddr);
      end
    end
  endtask

  task automatic test_wrap();
    step_t s[3];
    exp_t  e;
    s[0] = st(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h50, 1'b1, 1'b0, 32'hFFFF_FFFC);
    s[1] = idle(32'hFFFF_FFFC, 1'b0, 32'h0);
    s[2] = idle(32'h0, 1'b0, 32'h4);
    for (int i = 0; i < 3; i++) begin
      apply(s[i]);
      e = sb.pop_front();
      vectors++;
      if ({id_pc, id_inst, id_valid, id_mis} !== e) begin
        miscompares++;
        $display("FAIL wrap_ifid[%0d]: got %h/%h/%b/%b expected %h/%h/%b/%b", i,
                 id_pc, id_inst, id_valid, id_mis, e.pc, e.inst, e.valid, e.mis);
      end
      vectors++;
      if (rom_addr !== s[i].eaddr) begin
        miscompares++;
        $display("FAIL wrap_addr[%0d]: got %h expected %h", i, rom_addr, s[i].eaddr);
      end
    end
  endtask

  task automatic test_async_reset();
    step_t s[2];
    exp_t  e;
    rst_n = 1'b0;
    #2;
    vectors++;
    if ({rom_ce, id_valid, rom_addr, id_pc} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      miscompares++;
      $display("FAIL async_reset: got ce=%b v=%b addr=%h pc=%h expected 0/0/0/0", rom_ce, id_valid, rom_addr, id_pc);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s[0] = st(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    s[1] = idle(32'h0, 1'b0, 32'h4);
    for (int i = 0; i < 2; i++) begin
      apply(s[i]);
      e = sb.pop_front();
      vectors++;
      if ({id_pc, id_inst, id_valid, id_mis} !== e) begin
        miscompares++;
        $display("FAIL rerun_ifid[%0d]: got %h/%h/%b/%b expected %h/%h/%b/%b", i,
                 id_pc, id_inst, id_valid, id_mis, e.pc, e.inst, e.valid, e.mis);
      end
      vectors++;
      if ({rom_ce, rom_addr} !== {1'b1, s[i].eaddr}) begin
        miscompares++;
        $display("FAIL rerun_fetch[%0d]: got ce=%b addr=%h expected ce=1 addr=%h", i, rom_ce, rom_addr, s[i].eaddr);
      end
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    stall_if_i      = 1'b0;
    stall_id_i      = 1'b0;
    branch_flag_i   = 1'b0;
    flush_i         = 1'b0;
    branch_target_i = 32'h0;
    flush_pc_i      = 32'h0;
    test_reset();
    test_stall();
    test_branch();
    test_flush();
    test_misalign();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter and drives the address and chip-enable of the combinational instruction ROM. It captures the returned word plus its PC into the IF/ID pipeline register consumed by decode. It also handles stall, branch redirect, delay-slot policy and pipeline flush.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset and fetched first.
BRANCH_DELAY_SLOT, 1, 1 = instruction in IF when branch resolves is kept (MIPS delay slot); 0 = it is squashed to a bubble.

Ports:
clk  in  1  pipeline clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
stall_if_i  in  1  hold PC (from hazard control).
stall_id_i  in  1  decode stalled; hold IF/ID contents.
branch_flag_i  in  1  taken branch/jump resolved in ID.
branch_target_i  in  32  branch destination.
flush_i  in  1  exception/flush request; highest priority.
flush_pc_i  in  32  handler address loaded on flush.
rom_data_i  in  32  instruction word from ROM (`INST_BUS).
rom_addr_o  out  32  fetch address to ROM (`INST_ADDR_BUS) = current PC.
rom_ce_o  out  1  ROM chip enable (`CHIP_ENABLE/`CHIP_DISABLE).
id_pc_o  out  32  PC of instruction in IF/ID.
id_inst_o  out  32  instruction in IF/ID.
id_valid_o  out  1  IF/ID holds a real instruction.
id_misalign_o  out  1  IF/ID instruction came from a non-word-aligned redirect.

Behaviour:
- Reset (async, rst_n=0): rom_ce_o=`CHIP_DISABLE, pc=RESET_PC, id_pc_o=0, id_inst_o=`ZERO_WORD, id_valid_o=0, id_misalign_o=0.
- First rising edge after deassertion: ce goes `CHIP_ENABLE; pc stays RESET_PC because pc does not advance while ce is disabled. The first fetch is therefore RESET_PC, one cycle after release.
- rom_addr_o = pc combinationally; ROM data is valid the same cycle.
- PC update each edge while ce enabled, in priority order:
  - flush_i: pc<=flush_pc_i. Overrides stall.
  - stall_if_i: pc held. branch_flag_i is ignored; decode re-presents it.
  - branch_flag_i: pc<=branch_target_i.
  - otherwise: pc<=pc+4. Modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Misaligned redirect (target[1:0]!=0 on branch or flush): pc loads target with [1:0] forced to 00. A misalign flag travels with that fetch into IF/ID as id_misalign_o and clears on the next captured instruction.
- IF/ID register update each edge, in priority order:
  - flush_i: bubble (pc 0, inst `ZERO_WORD, valid 0, misalign 0).
  - stall_id_i: hold all fields.
  - stall_if_i with !stall_id_i: bubble.
  - branch_flag_i with BRANCH_DELAY_SLOT=0: bubble (squash wrong-path fetch).
  - otherwise: capture pc, rom_data_i, valid=1, misalign flag.
- ce disabled: ROM returns `ZERO_WORD; IF/ID captures it as valid=0.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); the next fetch is RESET_PC as above.
- flush and branch in the same cycle: flush wins.
- stall_id_i=1 with stall_if_i=0 is illegal from control. If it occurs, the PC advances and IF/ID holds, so one fetch is lost. The bench flags it with an assertion.

Decomposition:
- Shared `define include DEFINE.v holds:
  - `INST_ADDR_BUS and `INST_BUS.
  - `CHIP_ENABLE/`CHIP_DISABLE and `ZERO_WORD.
  - new `PC_STEP (32'd4) and `STALL_HOLD/`STALL_RUN.
- One natural sub-module, pc_reg: PC plus ce register with redirect priority.
- The IF/ID latch stays in the top module.

Test Plan:
- Reset release with ROM word 32'h34018000 at 0: the cycle after release has rom_ce_o=1 and rom_addr_o=0. The next edge gives id_inst_o=32'h34018000, id_pc_o=0, valid=1. Then the address steps 4, 8, 12.
- stall_if_i=1, stall_id_i=1 for 3 cycles at pc=0x10: rom_addr_o stays 0x10 and IF/ID holds. After release, fetch resumes at 0x10 then 0x14 with no instruction lost or duplicated.
- branch_flag_i=1, target 0x40, while IF holds 0x1C:
  - BRANCH_DELAY_SLOT=1: IF/ID gets 0x1C valid, next fetch 0x40.
  - BRANCH_DELAY_SLOT=0: IF/ID gets a bubble (valid 0), next fetch 0x40.
- flush_i with flush_pc_i=0x180 together with branch_flag_i (target 0x40) and stall_if_i: pc becomes 0x180 and IF/ID becomes a bubble. The branch and the stall are ignored.
- Redirect to 0x4A: rom_addr_o=0x48; that instruction reaches IF/ID with id_misalign_o=1, and the following one has it 0.
- pc=32'hFFFF_FFFC with no stall: next rom_addr_o=0. Asserting rst_n=0 mid-run forces rom_ce_o=0 and valid=0 before the next clock edge.
